// File: rtl/match_controller.sv
// Match controller: credits round wins on rising win edges, holds the playfield
// cleared after each credited round, and declares a champion at WIN_SCORE.
module match_controller #(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       lwin,
  input  logic       rwin,
  output logic       add1,
  output logic       add2,
  output logic       round_clr,
  output logic [2:0] score1,
  output logic [2:0] score2,
  output logic       game_over,
  output logic [1:0] champ
);

  typedef enum logic [1:0] {IDLE, PLAY, HOLD, OVER} state_t;

  localparam logic [2:0] WIN       = 3'(WIN_SCORE);
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES);

  state_t     state, state_nx;
  logic       lwin_q, rwin_q;
  logic       lwin_edge, rwin_edge;
  logic [3:0] hold_cnt, hold_cnt_nx;
  logic [2:0] score1_nx, score2_nx;
  logic [1:0] champ_nx;
  logic       add1_nx, add2_nx;

  assign lwin_edge = lwin & ~lwin_q;
  assign rwin_edge = rwin & ~rwin_q;

  always_comb begin
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    score1_nx   = score1;
    score2_nx   = score2;
    champ_nx    = champ;
    add1_nx     = 1'b0;
    add2_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = PLAY;
      end
      PLAY: begin
        // Simultaneous edges cancel: neither side is credited.
        if (lwin_edge && !rwin_edge && score1 < WIN) begin
          state_nx    = HOLD;
          add1_nx     = 1'b1;
          score1_nx   = score1 + 3'd1;
          hold_cnt_nx = HOLD_LOAD;
        end else if (rwin_edge && !lwin_edge && score2 < WIN) begin
          state_nx    = HOLD;
          add2_nx     = 1'b1;
          score2_nx   = score2 + 3'd1;
          hold_cnt_nx = HOLD_LOAD;
        end
      end
      HOLD: begin
        // hold_cnt counts the remaining HOLD cycles including the current one.
        if (hold_cnt <= 4'd1) begin
          hold_cnt_nx = 4'd0;
          if (score1 == WIN) begin
            state_nx = OVER;
            champ_nx = 2'b01;
          end else if (score2 == WIN) begin
            state_nx = OVER;
            champ_nx = 2'b10;
          end else begin
            state_nx = PLAY;
          end
        end else begin
          hold_cnt_nx = hold_cnt - 4'd1;
        end
      end
      OVER: begin
        if (start) begin
          state_nx  = PLAY;
          score1_nx = 3'd0;
          score2_nx = 3'd0;
          champ_nx  = 2'b00;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= IDLE;
      lwin_q    <= 1'b0;
      rwin_q    <= 1'b0;
      hold_cnt  <= 4'd0;
      score1    <= 3'd0;
      score2    <= 3'd0;
      champ     <= 2'b00;
      add1      <= 1'b0;
      add2      <= 1'b0;
      round_clr <= 1'b1;
      game_over <= 1'b0;
    end else begin
      state     <= state_nx;
      lwin_q    <= lwin;
      rwin_q    <= rwin;
      hold_cnt  <= hold_cnt_nx;
      score1    <= score1_nx;
      score2    <= score2_nx;
      champ     <= champ_nx;
      add1      <= add1_nx;
      add2      <= add2_nx;
      round_clr <= (state_nx != PLAY);
      game_over <= (state_nx == OVER);
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller: reset, single rounds, cancelled rounds,
// held inputs, a full match with restart, and reset in the middle of HOLD.
module tb_match_controller;

  logic       clk = 1'b0;
  logic       Reset, start, lwin, rwin;
  logic       add1, add2, round_clr, game_over;
  logic [2:0] score1, score2;
  logic [1:0] champ;
  int         n_cmp = 0;
  int         n_fail = 0;

  match_controller #(.WIN_SCORE(7), .HOLD_CYCLES(4)) dut (
    .clk(clk), .Reset(Reset), .start(start), .lwin(lwin), .rwin(rwin),
    .add1(add1), .add2(add2), .round_clr(round_clr),
    .score1(score1), .score2(score2), .game_over(game_over), .champ(champ)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then observed and inputs changed 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; start = 1'b0; lwin = 1'b0; rwin = 1'b0;
    repeat (3) step();
    Reset = 1'b0;
  endtask

  // One credited round: edge on the chosen input, then the 4 HOLD cycles.
  task automatic play_round(input logic p1);
    if (p1) lwin = 1'b1; else rwin = 1'b1;
    step();
    lwin = 1'b0; rwin = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (round_clr !== 1'b1 || score1 !== 3'd0 || score2 !== 3'd0 || champ !== 2'b00 ||
        add1 !== 1'b0 || add2 !== 1'b0 || game_over !== 1'b0) begin
      $display("FAIL reset_state: clr=%b s1=%0d s2=%0d champ=%b add=%b%b go=%b, want 1 0 0 00 00 0",
               round_clr, score1, score2, champ, add1, add2, game_over);
      n_fail++;
    end
    step();
    n_cmp++;
    if (round_clr !== 1'b1) begin
      $display("FAIL idle_hold: round_clr=%b want 1", round_clr); n_fail++;
    end
    // Reset wins over start in the same cycle.
    Reset = 1'b1; start = 1'b1;
    step();
    Reset = 1'b0; start = 1'b0;
    n_cmp++;
    if (round_clr !== 1'b1) begin
      $display("FAIL reset_priority: round_clr=%b want 1", round_clr); n_fail++;
    end
  endtask

  task automatic test_lwin_round();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (round_clr !== 1'b0) begin
      $display("FAIL start_to_play: round_clr=%b want 0", round_clr); n_fail++;
    end
    lwin = 1'b1;
    step();
    lwin = 1'b0;
    n_cmp++;
    if (add1 !== 1'b1 || add2 !== 1'b0 || score1 !== 3'd1 || round_clr !== 1'b1) begin
      $display("FAIL lwin_credit: add1=%b add2=%b s1=%0d clr=%b want 1 0 1 1",
               add1, add2, score1, round_clr);
      n_fail++;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (add1 !== 1'b0 || round_clr !== 1'b1 || score1 !== 3'd1) begin
        $display("FAIL hold_cycle%0d: add1=%b clr=%b s1=%0d want 0 1 1", i + 2, add1, round_clr, score1);
        n_fail++;
      end
    end
    step();
    n_cmp++;
    if (round_clr !== 1'b0 || game_over !== 1'b0) begin
      $display("FAIL hold_exit: clr=%b go=%b want 0 0", round_clr, game_over); n_fail++;
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    lwin = 1'b1; rwin = 1'b1;
    step();
    n_cmp++;
    if (add1 !== 1'b0 || add2 !== 1'b0 || score1 !== 3'd0 || score2 !== 3'd0 || round_clr !== 1'b0) begin
      $display("FAIL simultaneous: add=%b%b s1=%0d s2=%0d clr=%b want 00 0 0 0",
               add1, add2, score1, score2, round_clr);
      n_fail++;
    end
    step();
    lwin = 1'b0; rwin = 1'b0;
    n_cmp++;
    if (add1 !== 1'b0 || add2 !== 1'b0 || round_clr !== 1'b0) begin
      $display("FAIL simultaneous_held: add=%b%b clr=%b want 00 0", add1, add2, round_clr);
      n_fail++;
    end
  endtask

  task automatic test_rwin_held();
    int pulses;
    pulses = 0;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    rwin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (add2 === 1'b1) pulses++;
    end
    rwin = 1'b0;
    n_cmp++;
    if (pulses != 1 || score2 !== 3'd1 || score1 !== 3'd0) begin
      $display("FAIL rwin_held: pulses=%0d s2=%0d s1=%0d want 1 1 0", pulses, score2, score1);
      n_fail++;
    end
  endtask

  task automatic test_match();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      play_round(1'b1);
      n_cmp++;
      if (score1 !== 3'(k) || round_clr !== 1'b0 || game_over !== 1'b0) begin
        $display("FAIL match_round%0d: s1=%0d clr=%b go=%b want %0d 0 0", k, score1, round_clr, game_over, k);
        n_fail++;
      end
    end
    play_round(1'b1);
    n_cmp++;
    if (game_over !== 1'b1 || champ !== 2'b01 || score1 !== 3'd7 || round_clr !== 1'b1) begin
      $display("FAIL match_over: go=%b champ=%b s1=%0d clr=%b want 1 01 7 1",
               game_over, champ, score1, round_clr);
      n_fail++;
    end
    // Win inputs are ignored in OVER.
    lwin = 1'b1;
    step();
    lwin = 1'b0;
    step();
    n_cmp++;
    if (add1 !== 1'b0 || score1 !== 3'd7 || game_over !== 1'b1) begin
      $display("FAIL over_ignores_win: add1=%b s1=%0d go=%b want 0 7 1", add1, score1, game_over);
      n_fail++;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (score1 !== 3'd0 || score2 !== 3'd0 || champ !== 2'b00 || game_over !== 1'b0 || round_clr !== 1'b0) begin
      $display("FAIL restart: s1=%0d s2=%0d champ=%b go=%b clr=%b want 0 0 00 0 0",
               score1, score2, champ, game_over, round_clr);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    play_round(1'b0);
    play_round(1'b0);
    rwin = 1'b1;
    step();
    rwin = 1'b0;
    step();
    n_cmp++;
    if (score2 !== 3'd3 || round_clr !== 1'b1) begin
      $display("FAIL pre_reset_hold: s2=%0d clr=%b want 3 1", score2, round_clr); n_fail++;
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    n_cmp++;
    if (score2 !== 3'd0 || add1 !== 1'b0 || add2 !== 1'b0 || round_clr !== 1'b1 || champ !== 2'b00) begin
      $display("FAIL reset_mid_hold: s2=%0d add=%b%b clr=%b champ=%b want 0 00 1 00",
               score2, add1, add2, round_clr, champ);
      n_fail++;
    end
    // Still IDLE: an edge on lwin is not credited.
    lwin = 1'b1;
    step();
    lwin = 1'b0;
    n_cmp++;
    if (add1 !== 1'b0 || score1 !== 3'd0 || round_clr !== 1'b1) begin
      $display("FAIL idle_after_reset: add1=%b s1=%0d clr=%b want 0 0 1", add1, score1, round_clr);
      n_fail++;
    end
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; lwin = 1'b0; rwin = 1'b0;
    test_reset();
    test_lwin_round();
    test_simultaneous();
    test_rwin_held();
    test_match();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
